// File: rtl/mult_pkg.sv
// Shared definitions for the 8-bit shift-and-add multiplier.
// Contents:
//   MULT_WIDTH   - operand width shared by the controller, the accumulator and the B register
//   state_t      - controller state encoding (2 bits)
//   ctrl_t       - bundle of the registered control strobes
//   decode_ctrl  - Moore decode of the strobes from a state
package mult_pkg;

    localparam int unsigned MULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CALC = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic ld_a;
        logic ld_b;
        logic shift_b;
        logic clr_acc;
        logic ld_acc;
        logic busy;
        logic done;
    } ctrl_t;

    // Strobe values for the cycle spent in state s.
    function automatic ctrl_t decode_ctrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            LOAD: begin
                c.ld_a    = 1'b1;
                c.ld_b    = 1'b1;
                c.clr_acc = 1'b1;
                c.busy    = 1'b1;
            end
            CALC: begin
                c.shift_b = 1'b1;
                c.ld_acc  = 1'b1;
                c.busy    = 1'b1;
            end
            DONE: begin
                c.done    = 1'b1;
            end
            default: begin
                c = '0;
            end
        endcase
        return c;
    endfunction

endpackage

// File: rtl/shift_add_mult_ctrl_if.sv
// Handshake and datapath-control bundle between the multiplier controller,
// its host and the datapath registers.
// Signals:
//   start, b_lsb                       - into the controller
//   ld_A, ld_B, shift_B, clr_ACC,
//   ld_ACC, sel_sum                    - datapath control from the controller
//   busy, done, step_cnt               - status from the controller
// Modports: master = controller side, slave = host/datapath side.
interface shift_add_mult_ctrl_if #(
    parameter int unsigned CNT_W = 3
);

    logic             start;
    logic             b_lsb;
    logic             ld_A;
    logic             ld_B;
    logic             shift_B;
    logic             clr_ACC;
    logic             ld_ACC;
    logic             sel_sum;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] step_cnt;

    modport master (
        input  start,
        input  b_lsb,
        output ld_A,
        output ld_B,
        output shift_B,
        output clr_ACC,
        output ld_ACC,
        output sel_sum,
        output busy,
        output done,
        output step_cnt
    );

    modport slave (
        output start,
        output b_lsb,
        input  ld_A,
        input  ld_B,
        input  shift_B,
        input  clr_ACC,
        input  ld_ACC,
        input  sel_sum,
        input  busy,
        input  done,
        input  step_cnt
    );

endinterface

// File: rtl/mult_step_counter.sv
// Add/shift step counter: counts 0..WIDTH-1 and returns to 0 after the last step.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clear       - force count to 0 (takes priority over enable)
//   enable      - advance one step
//   count       - registered step index
//   terminal_c  - combinational flag, count is at the last step (WIDTH-1)
module mult_step_counter #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             enable,
    output logic [CNT_W-1:0] count,
    output logic             terminal_c
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    assign terminal_c = (count == LAST);

    // Explicit return to 0 so non-power-of-two widths never run past LAST.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= terminal_c ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Control FSM for the shift-and-add multiplier datapath. Loads A and B,
// clears the accumulator, runs WIDTH add/shift steps and pulses done for one
// cycle while the product {ACC,B} is valid.
// Ports:
//   i_clk    - rising-edge clock
//   i_rst_n  - synchronous active-low reset
//   bus      - handshake/control bundle (master side):
//              start, b_lsb in; ld_A, ld_B, shift_B, clr_ACC, ld_ACC,
//              sel_sum (combinational), busy, done, step_cnt out
module shift_add_mult_ctrl
    import mult_pkg::*;
#(
    parameter  int unsigned WIDTH = MULT_WIDTH,
    localparam int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    shift_add_mult_ctrl_if.master bus
);

    state_t           state;
    state_t           state_nxt;
    ctrl_t            ctrl_q;
    logic [CNT_W-1:0] count;
    logic             terminal;
    logic             cnt_clear;
    logic             cnt_enable;

    // Counter follows the registered state: held at 0 in LOAD, stepping in CALC.
    assign cnt_clear  = (state == LOAD);
    assign cnt_enable = (state == CALC);

    mult_step_counter #(
        .WIDTH (WIDTH)
    ) u_step_counter (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (cnt_clear),
        .enable     (cnt_enable),
        .count      (count),
        .terminal_c (terminal)
    );

    // Next-state decision; start only matters in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = bus.start ? LOAD : IDLE;
            LOAD:    state_nxt = CALC;
            CALC:    state_nxt = terminal ? DONE : CALC;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; strobes are registered alongside, decoded from the next state
    // so they line up with the state they belong to.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state  <= IDLE;
            ctrl_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= decode_ctrl(state_nxt);
        end
    end

    assign bus.ld_A     = ctrl_q.ld_a;
    assign bus.ld_B     = ctrl_q.ld_b;
    assign bus.shift_B  = ctrl_q.shift_b;
    assign bus.clr_ACC  = ctrl_q.clr_acc;
    assign bus.ld_ACC   = ctrl_q.ld_acc;
    assign bus.busy     = ctrl_q.busy;
    assign bus.done     = ctrl_q.done;
    assign bus.step_cnt = count;

    // Adder operand select follows the live B LSB, gated to the add/shift phase.
    assign bus.sel_sum  = bus.b_lsb & (state == CALC);

    // Strobe pairs that would corrupt the datapath if ever asserted together.
    a_acc_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 !(bus.clr_ACC && bus.ld_ACC));
    a_b_excl:   assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 !(bus.ld_B && bus.shift_B));
    a_hs_excl:  assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                 !(bus.busy && bus.done));

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
module tb_shift_add_mult_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] IDLE_V = 7'b0000000;
    localparam logic [6:0] LOAD_V = 7'b1101010;
    localparam logic [6:0] CALC_V = 7'b0010110;
    localparam logic [6:0] DONE_V = 7'b0000001;

    shift_add_mult_ctrl_if #(.CNT_W(3)) bus8 ();
    shift_add_mult_ctrl_if #(.CNT_W(2)) bus4 ();

    shift_add_mult_ctrl #(.WIDTH(8)) dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus8)
    );

    shift_add_mult_ctrl #(.WIDTH(4)) dut4 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus4)
    );

    // Behavioural datapath for the 8-bit instance
    logic [7:0] a_in = 8'h00, b_in = 8'h00;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_acc = 8'h00;
    logic [8:0] m_sum;
    always_comb m_sum = {1'b0, m_acc} + {1'b0, (bus8.sel_sum ? m_a : 8'h00)};
    always @(posedge clk) begin
        if (bus8.ld_A) m_a <= a_in;
        if (bus8.ld_B) m_b <= b_in;
        else if (bus8.shift_B) m_b <= {m_sum[0], m_b[7:1]};
        if (bus8.clr_ACC) m_acc <= 8'h00;
        else if (bus8.ld_ACC) m_acc <= m_sum[8:1];
    end
    assign bus8.b_lsb = m_b[0];

    // Behavioural datapath for the 4-bit instance
    logic [3:0] a4_in = 4'h0, b4_in = 4'h0;
    logic [3:0] m4_a = 4'h0, m4_b = 4'h0, m4_acc = 4'h0;
    logic [4:0] m4_sum;
    always_comb m4_sum = {1'b0, m4_acc} + {1'b0, (bus4.sel_sum ? m4_a : 4'h0)};
    always @(posedge clk) begin
        if (bus4.ld_A) m4_a <= a4_in;
        if (bus4.ld_B) m4_b <= b4_in;
        else if (bus4.shift_B) m4_b <= {m4_sum[0], m4_b[3:1]};
        if (bus4.clr_ACC) m4_acc <= 4'h0;
        else if (bus4.ld_ACC) m4_acc <= m4_sum[4:1];
    end
    assign bus4.b_lsb = m4_b[0];

    function automatic logic [6:0] vec8();
        return {bus8.ld_A, bus8.ld_B, bus8.shift_B, bus8.clr_ACC, bus8.ld_ACC, bus8.busy, bus8.done};
    endfunction

    function automatic logic [6:0] vec4();
        return {bus4.ld_A, bus4.ld_B, bus4.shift_B, bus4.clr_ACC, bus4.ld_ACC, bus4.busy, bus4.done};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe exclusion checked every cycle out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            tests = tests + 1;
            if (((bus8.clr_ACC & bus8.ld_ACC) | (bus8.ld_B & bus8.shift_B) | (bus8.busy & bus8.done)) !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL excl: clr/ld_acc=%b%b ld/shift_b=%b%b busy/done=%b%b required no pair both 1",
                         bus8.clr_ACC, bus8.ld_ACC, bus8.ld_B, bus8.shift_B, bus8.busy, bus8.done);
            end
        end
    end

    // One full multiply on the 8-bit instance starting from IDLE
    task automatic do_mult8(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_p, input bit pulse_in_calc);
        a_in = a;
        b_in = b;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        tests = tests + 1;
        if (vec8() !== LOAD_V || bus8.step_cnt !== 3'd0) begin
            fails = fails + 1;
            $display("FAIL load: ctrl=%b cnt=%0d required ctrl=%b cnt=0", vec8(), bus8.step_cnt, LOAD_V);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests = tests + 1;
            if (vec8() !== CALC_V || bus8.step_cnt !== 3'(i) || bus8.sel_sum !== b[i]) begin
                fails = fails + 1;
                $display("FAIL calc step %0d: ctrl=%b cnt=%0d sel=%b required ctrl=%b cnt=%0d sel=%b",
                         i, vec8(), bus8.step_cnt, bus8.sel_sum, CALC_V, i, b[i]);
            end
            bus8.start = pulse_in_calc && (i == 2 || i == 5);
        end
        bus8.start = 1'b0;
        tick();
        tests = tests + 1;
        if (vec8() !== DONE_V || bus8.step_cnt !== 3'd0 || {m_acc, m_b} !== exp_p) begin
            fails = fails + 1;
            $display("FAIL done %h*%h: ctrl=%b cnt=%0d prod=%h required ctrl=%b cnt=0 prod=%h",
                     a, b, vec8(), bus8.step_cnt, {m_acc, m_b}, DONE_V, exp_p);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            tests = tests + 1;
            if (vec8() !== IDLE_V || bus8.sel_sum !== 1'b0) begin
                fails = fails + 1;
                $display("FAIL idle after done %0d: ctrl=%b sel=%b required ctrl=%b sel=0",
                         k, vec8(), bus8.sel_sum, IDLE_V);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests = tests + 1;
            if (vec8() !== IDLE_V || bus8.sel_sum !== 1'b0 || bus8.step_cnt !== 3'd0) begin
                fails = fails + 1;
                $display("FAIL reset cycle %0d: ctrl=%b sel=%b cnt=%0d required all 0",
                         i, vec8(), bus8.sel_sum, bus8.step_cnt);
            end
        end
        rst_n = 1'b1;
        tick();
        tests = tests + 1;
        if (vec8() !== LOAD_V) begin
            fails = fails + 1;
            $display("FAIL reset release: ctrl=%b required %b", vec8(), LOAD_V);
        end
        bus8.start = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        tests = tests + 1;
        if (vec8() !== IDLE_V) begin
            fails = fails + 1;
            $display("FAIL reset settle: ctrl=%b required %b", vec8(), IDLE_V);
        end
    endtask

    task automatic test_sequencing();
        // 0x03*0xB5 = 543; sel_sum pattern 1,0,1,0,1,1,0,1; start pulses in CALC ignored
        do_mult8(8'h03, 8'hB5, 16'h021F, 1'b1);
    endtask

    task automatic test_arith();
        do_mult8(8'h0D, 8'h0B, 16'h008F, 1'b0);
        do_mult8(8'hFF, 8'hFF, 16'hFE01, 1'b0);
        do_mult8(8'h00, 8'hA7, 16'h0000, 1'b0);
    endtask

    task automatic test_back_to_back();
        int loads = 0;
        int dones = 0;
        int load_t[4];
        a_in = 8'h0D;
        b_in = 8'h0B;
        bus8.start = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (bus8.ld_A === 1'b1) begin
                if (loads < 4) load_t[loads] = t;
                loads = loads + 1;
            end
            if (bus8.done === 1'b1) begin
                dones = dones + 1;
                tests = tests + 1;
                if ({m_acc, m_b} !== 16'h008F) begin
                    fails = fails + 1;
                    $display("FAIL b2b product t=%0d: got %h required 008f", t, {m_acc, m_b});
                end
            end
            if (t == 11) begin
                tests = tests + 1;
                if (vec8() !== IDLE_V) begin
                    fails = fails + 1;
                    $display("FAIL b2b idle gap: ctrl=%b required %b", vec8(), IDLE_V);
                end
            end
        end
        tests = tests + 1;
        if (loads !== 3 || dones !== 2) begin
            fails = fails + 1;
            $display("FAIL b2b counts: loads=%0d dones=%0d required loads=3 dones=2", loads, dones);
        end
        tests = tests + 1;
        if (loads >= 3 && (load_t[0] !== 1 || load_t[1] !== 12 || load_t[2] !== 23)) begin
            fails = fails + 1;
            $display("FAIL b2b load times: %0d,%0d,%0d required 1,12,23", load_t[0], load_t[1], load_t[2]);
        end
        bus8.start = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        tests = tests + 1;
        if (vec8() !== IDLE_V) begin
            fails = fails + 1;
            $display("FAIL b2b drain: ctrl=%b required %b", vec8(), IDLE_V);
        end
    endtask

    task automatic test_reset_mid();
        bit seen_done = 1'b0;
        a_in = 8'h55;
        b_in = 8'h33;
        bus8.start = 1'b1;
        tick();
        bus8.start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests = tests + 1;
        if (vec8() !== CALC_V || bus8.step_cnt !== 3'd4) begin
            fails = fails + 1;
            $display("FAIL abort setup: ctrl=%b cnt=%0d required ctrl=%b cnt=4", vec8(), bus8.step_cnt, CALC_V);
        end
        rst_n = 1'b0;
        tick();
        tests = tests + 1;
        if (vec8() !== IDLE_V || bus8.step_cnt !== 3'd0 || bus8.sel_sum !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL abort: ctrl=%b cnt=%0d sel=%b required all 0", vec8(), bus8.step_cnt, bus8.sel_sum);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) seen_done = 1'b1;
        end
        tests = tests + 1;
        if (seen_done !== 1'b0) begin
            fails = fails + 1;
            $display("FAIL abort no done: activity seen=%b required 0", seen_done);
        end
        do_mult8(8'h03, 8'h05, 16'h000F, 1'b0);
    endtask

    task automatic test_width4();
        a4_in = 4'hF;
        b4_in = 4'hF;
        bus4.start = 1'b1;
        tick();
        bus4.start = 1'b0;
        tests = tests + 1;
        if (vec4() !== LOAD_V) begin
            fails = fails + 1;
            $display("FAIL w4 load: ctrl=%b required %b", vec4(), LOAD_V);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests = tests + 1;
            if (vec4() !== CALC_V || bus4.step_cnt !== 2'(i)) begin
                fails = fails + 1;
                $display("FAIL w4 calc %0d: ctrl=%b cnt=%0d required ctrl=%b cnt=%0d",
                         i, vec4(), bus4.step_cnt, CALC_V, i);
            end
        end
        tick();
        tests = tests + 1;
        if (vec4() !== DONE_V || {m4_acc, m4_b} !== 8'hE1) begin
            fails = fails + 1;
            $display("FAIL w4 done: ctrl=%b prod=%h required ctrl=%b prod=e1", vec4(), {m4_acc, m4_b}, DONE_V);
        end
        tick();
        tests = tests + 1;
        if (vec4() !== IDLE_V) begin
            fails = fails + 1;
            $display("FAIL w4 idle: ctrl=%b required %b", vec4(), IDLE_V);
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus4.start = 1'b0;
        rst_n = 1'b0;
        test_reset();
        test_sequencing();
        test_arith();
        test_back_to_back();
        test_reset_mid();
        test_width4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
